image_filter_core: RTL and testbench
====================================

Name: image_filter_core

Overview:
- Streaming per-pixel image filter: converts a frame of 24-bit RGB pixels into 8-bit filtered pixels.
- Generates the read address for an external pixel memory and accepts one pixel per cycle while validData is high.
- Emits one registered result per accepted pixel.
- Sits between the frame buffer (pixel source) and the result sink/display writer.

Parameters:
- THRESH, 128, gray-level threshold for filter code 2 (8-bit, compared with >=).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- validData  in  1  pixel_in holds valid data for the current Pixel_address.
- start  in  1  level; frame start request.
- size  in  2  frame size code: 0 = 4x4 (16 px), 1 = 8x8 (64 px), 2 = 16x16 (256 px), 3 = 16x16 (256 px).
- filter  in  2  filter code: 0 = grayscale, 1 = negative gray, 2 = threshold, 3 = max channel.
- pixel_in  in  24  {R[23:16], G[15:8], B[7:0]}.
- ValidResult  out  1  pixel_out valid this cycle (one-cycle pulse per result).
- Pixel_address  out  8  address of the pixel currently requested, registered.
- pixel_out  out  8  filtered pixel, registered.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; Pixel_address=0, pixel_out=0, ValidResult=0; latched size/filter cleared to 0.
- Reset mid-frame aborts the frame immediately with the same values.
- States:
  - IDLE: Pixel_address held 0, validData ignored. start=1 -> RUN; size and filter latched on that edge.
  - RUN: each cycle with validData=1, pixel_in is accepted for the current Pixel_address. On the next edge: pixel_out<=f(pixel_in), ValidResult<=1.
    - If Pixel_address==N-1: Pixel_address<=0, go to DONE. Otherwise Pixel_address<=Pixel_address+1.
    - validData=0: address holds and ValidResult<=0 (stall, no timeout).
    - start ignored in RUN.
    - size/filter changes mid-frame are ignored (latched copies used).
  - DONE: ValidResult<=0. Waits for start=0, then -> IDLE. A held-high start does not retrigger a frame.
- Latency: exactly 1 clock from accepted pixel to ValidResult/pixel_out. Throughput: 1 pixel/clock.
- ValidResult is 0 in every cycle without a newly accepted pixel.
- Filter arithmetic (unsigned):
  - gray = (R + 2*G + B) >> 2, using a 10-bit sum; result fits 8 bits, no saturation needed.
  - code 0: gray.
  - code 1: 255 - gray.
  - code 2: gray >= THRESH ? 255 : 0.
  - code 3: max(R, G, B).
- Address wrap: the last pixel is N-1 (15/63/255). The 8-bit counter never overflows because the terminal compare precedes increment.

Decomposition:
- Package img_pkg: state enum (IDLE, RUN, DONE); size codes and a function returning last address (15/63/255); filter code constants.
- Sub-module pixel_filter: combinational; inputs pixel_in[23:0], filter[1:0]; output result[7:0].
- Top holds the FSM, address counter and output registers.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with start=1, validData=1 -> ValidResult=0, Pixel_address=0, pixel_out=0, no frame starts.
- Grayscale stream: size=0, filter=0, start=1, validData=1, pixels {200,100,20}, {120,10,53}, {210,82,20}, {10,52,20}, {20,82,15} -> pixel_out 105, 48, 98, 33, 49 each one cycle later; Pixel_address 0,1,2,3,4.
- Filters on {200,100,20}: code 1 -> 150; code 2 (THRESH=128) -> 0; code 3 -> 200. {255,255,255} with code 2 -> 255.
- Stall: validData toggles 1,0,0,1 -> address advances only on the 1 cycles; ValidResult pulses exactly twice.
- Frame end: size=0, 16 valid pixels -> last result at address 15, then DONE, address=0. With start held high no further ValidResult; start low -> IDLE; start high -> new frame.
- Mid-frame: change filter/size after 3 pixels -> results keep the latched filter. Reset at pixel 5 -> outputs cleared, state IDLE.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and helpers for the streaming image filter.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [1:0] SZ_4X4   = 2'd0;
    localparam logic [1:0] SZ_8X8   = 2'd1;
    localparam logic [1:0] SZ_16X16 = 2'd2;
    localparam logic [1:0] SZ_16ALT = 2'd3;

    localparam logic [1:0] F_GRAY = 2'd0;
    localparam logic [1:0] F_NEG  = 2'd1;
    localparam logic [1:0] F_THR  = 2'd2;
    localparam logic [1:0] F_MAX  = 2'd3;

    function automatic logic [7:0] last_addr(input logic [1:0] sz);
        logic [7:0] a;
        unique case (sz)
            SZ_4X4:   a = 8'd15;
            SZ_8X8:   a = 8'd63;
            SZ_16X16: a = 8'd255;
            SZ_16ALT: a = 8'd255;
            default:  a = 8'd255;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pixel_filter.sv
// Combinational RGB-to-8-bit filter selected by a 2-bit code.
module pixel_filter
    import img_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic [23:0] pixel_in,
    input  logic [1:0]  filter,
    output logic [7:0]  result
);

    logic [7:0] r, g, b;
    logic [9:0] sum;
    logic [7:0] gray;
    logic [7:0] mx_rg;
    logic [7:0] mx;

    assign r = pixel_in[23:16];
    assign g = pixel_in[15:8];
    assign b = pixel_in[7:0];

    // R + 2G + B peaks at 1020, so 10 bits hold it without overflow
    assign sum   = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    assign gray  = sum[9:2];
    assign mx_rg = (r >= g) ? r : g;
    assign mx    = (mx_rg >= b) ? mx_rg : b;

    always_comb begin
        result = gray;
        unique case (filter)
            F_GRAY:  result = gray;
            F_NEG:   result = 8'd255 - gray;
            F_THR:   result = (gray >= THRESH) ? 8'd255 : 8'd0;
            F_MAX:   result = mx;
            default: result = gray;
        endcase
    end

endmodule

// File: rtl/image_filter_core.sv
// Frame sequencer: address generation, pixel acceptance, registered results.
module image_filter_core
    import img_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validData,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [1:0]  filter,
    input  logic [23:0] pixel_in,
    output logic        ValidResult,
    output logic [7:0]  Pixel_address,
    output logic [7:0]  pixel_out
);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] pix_q, pix_d;
    logic       vld_q, vld_d;
    logic [1:0] size_q, size_d;
    logic [1:0] filt_q, filt_d;
    logic [7:0] res;

    pixel_filter #(
        .THRESH(THRESH)
    ) u_filt (
        .pixel_in(pixel_in),
        .filter  (filt_q),
        .result  (res)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        vld_d   = 1'b0;
        size_d  = size_q;
        filt_d  = filt_q;
        unique case (state_q)
            IDLE: begin
                addr_d = 8'd0;
                if (start) begin
                    state_d = RUN;
                    size_d  = size;
                    filt_d  = filter;
                end
            end
            RUN: begin
                if (validData) begin
                    pix_d = res;
                    vld_d = 1'b1;
                    // terminal compare before increment keeps 8 bits enough
                    if (addr_q == last_addr(size_q)) begin
                        addr_d  = 8'd0;
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 8'd0;
            pix_q   <= 8'd0;
            vld_q   <= 1'b0;
            size_q  <= 2'd0;
            filt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
            size_q  <= size_d;
            filt_q  <= filt_d;
        end
    end

    assign ValidResult   = vld_q;
    assign Pixel_address = addr_q;
    assign pixel_out     = pix_q;

endmodule

// File: tb/tb_image_filter_core.sv
// Randomized and directed checks of image_filter_core against a frame model.
module tb_image_filter_core;

    localparam int TH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validData;
    logic        start;
    logic [1:0]  size;
    logic [1:0]  filter;
    logic [23:0] pixel_in;
    logic        ValidResult;
    logic [7:0]  Pixel_address;
    logic [7:0]  pixel_out;

    int n_vec = 0;
    int n_err = 0;

    // model: frame phase 0=waiting, 1=streaming, 2=finished
    int m_ph = 0;
    int m_idx = 0;
    int m_pix = 0;
    int m_vld = 0;
    int m_size = 0;
    int m_filt = 0;

    always #5 clk = ~clk;

    image_filter_core #(
        .THRESH(8'd128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .validData    (validData),
        .start        (start),
        .size         (size),
        .filter       (filter),
        .pixel_in     (pixel_in),
        .ValidResult  (ValidResult),
        .Pixel_address(Pixel_address),
        .pixel_out    (pixel_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_f(input logic [23:0] p, input int f);
        int r, g, b, gray, mx;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        gray = (r + 2 * g + b) / 4;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        case (f)
            0: return gray;
            1: return 255 - gray;
            2: return (gray >= TH) ? 255 : 0;
            default: return mx;
        endcase
    endfunction

    function automatic int frame_px(input int sz);
        int side;
        side = 4 << sz;
        if (side > 16) side = 16;
        return side * side;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_ph = 0; m_idx = 0; m_pix = 0;
            m_vld = 0; m_size = 0; m_filt = 0;
        end else if (m_ph == 0) begin
            m_vld = 0;
            if (start) begin
                m_ph = 1;
                m_size = int'(size);
                m_filt = int'(filter);
            end
        end else if (m_ph == 1) begin
            m_vld = 0;
            if (validData) begin
                m_pix = ref_f(pixel_in, m_filt);
                m_vld = 1;
                m_idx++;
                if (m_idx == frame_px(m_size)) begin
                    m_idx = 0;
                    m_ph = 2;
                end
            end
        end else begin
            m_vld = 0;
            if (!start) m_ph = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("valid", 32'(ValidResult), 32'(m_vld));
        check("addr", 32'(Pixel_address), 32'(m_idx));
        check("pix", 32'(pixel_out), 32'(m_pix));
    endtask

    task automatic pix(input logic [23:0] p, input int exp);
        validData = 1'b1;
        pixel_in = p;
        step();
        check("directed", 32'(pixel_out), 32'(exp));
        check("dvalid", 32'(ValidResult), 32'd1);
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 300 && m_ph == 1; i++) begin
            validData = 1'b1;
            pixel_in = 24'($urandom);
            step();
        end
        validData = 1'b0;
    endtask

    task automatic new_frame(input logic [1:0] sz, input logic [1:0] f);
        start = 1'b0;
        step();
        step();
        size = sz;
        filter = f;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        validData = 1'b1;
        size = 2'd2;
        filter = 2'd3;
        pixel_in = 24'hFFFFFF;
        step();
        step();
        check("rst_valid", 32'(ValidResult), 32'd0);
        check("rst_addr", 32'(Pixel_address), 32'd0);
        check("rst_pix", 32'(pixel_out), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();

        // grayscale stream
        new_frame(2'd0, 2'd0);
        pix({8'd200, 8'd100, 8'd20}, 105);
        pix({8'd120, 8'd10, 8'd53}, 48);
        pix({8'd210, 8'd82, 8'd20}, 98);
        pix({8'd10, 8'd52, 8'd20}, 33);
        pix({8'd20, 8'd82, 8'd15}, 49);
        check("addr5", 32'(Pixel_address), 32'd5);

        // stall pattern 1,0,0,1
        validData = 1'b1; pixel_in = 24'($urandom); step();
        validData = 1'b0; step();
        check("stall_v", 32'(ValidResult), 32'd0);
        step();
        validData = 1'b1; pixel_in = 24'($urandom); step();
        check("stall_a", 32'(Pixel_address), 32'd7);
        finish_frame();
        check("done_addr", 32'(Pixel_address), 32'd0);

        // held start must not retrigger
        start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        step();

        new_frame(2'd0, 2'd1);
        pix({8'd200, 8'd100, 8'd20}, 150);
        finish_frame();
        new_frame(2'd0, 2'd2);
        pix({8'd200, 8'd100, 8'd20}, 0);
        pix({8'd255, 8'd255, 8'd255}, 255);
        finish_frame();
        new_frame(2'd0, 2'd3);
        pix({8'd200, 8'd100, 8'd20}, 200);
        finish_frame();

        // mid-frame input changes, then reset mid-frame
        new_frame(2'd1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            validData = 1'b1; pixel_in = 24'($urandom); step();
        end
        size = 2'd0;
        filter = 2'd0;
        pix({8'd10, 8'd200, 8'd30}, 200);
        validData = 1'b1; pixel_in = 24'($urandom); step();
        rst_n = 1'b0;
        step();
        check("mid_rst_v", 32'(ValidResult), 32'd0);
        check("mid_rst_p", 32'(pixel_out), 32'd0);
        rst_n = 1'b1;
        validData = 1'b1;
        step();
        check("idle_addr", 32'(Pixel_address), 32'd0);

        // random soak
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 3) != 0);
            validData = ($urandom_range(0, 3) != 0);
            size = 2'($urandom);
            filter = 2'($urandom);
            pixel_in = 24'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
